// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared position widths, state and direction types for the pong ball logic
`ifndef X_POS_W
`define X_POS_W 10
`endif
`ifndef Y_POS_W
`define Y_POS_W 9
`endif

package pong_pkg;
    localparam int X_POS_W = `X_POS_W;
    localparam int Y_POS_W = `Y_POS_W;

    typedef enum logic [1:0] {IDLE, SERVE, PLAY, SCORED} ball_state_t;
    typedef enum logic {POS, NEG} dir_t;
endpackage

// File: rtl/ball_axis_step.sv
// rtl/ball_axis_step.sv - one axis of ball motion: step by speed, clamp and reflect at lo/hi limits
module ball_axis_step
    import pong_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [W-1:0] pos,
    input  dir_t         dir,
    input  logic [W-1:0] speed,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    output logic [W-1:0] next_pos,
    output dir_t         next_dir,
    output logic         hit
);
    logic signed [W+1:0] pos_s;
    logic signed [W+1:0] speed_s;
    logic signed [W+1:0] raw;

    // Two guard bits keep pos-speed below zero and pos+speed past 2**W representable.
    always_comb begin
        pos_s    = {2'b00, pos};
        speed_s  = {2'b00, speed};
        raw      = (dir == POS) ? pos_s + speed_s : pos_s - speed_s;
        next_pos = raw[W-1:0];
        next_dir = dir;
        hit      = 1'b0;
        if (raw <= $signed({2'b00, lo})) begin
            next_pos = lo;
            next_dir = POS;
            hit      = 1'b1;
        end else if (raw >= $signed({2'b00, hi})) begin
            next_pos = hi;
            next_dir = NEG;
            hit      = 1'b1;
        end
    end
endmodule

// File: rtl/ball_controller.sv
// rtl/ball_controller.sv - ball sprite sequencer: serve/play/score FSM, one position step per frame tick
module ball_controller
    import pong_pkg::*;
#(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int BALL_SIZE    = 10,
    parameter int PADDLE_W     = 10,
    parameter int PADDLE_H     = 60,
    parameter int L_PADDLE_X   = 20,
    parameter int R_PADDLE_X   = 610,
    parameter int BALL_SPEED   = 2,
    parameter int SERVE_FRAMES = 60
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               frame_tick_i,
    input  logic               start_i,
    input  logic [Y_POS_W-1:0] l_paddle_y_i,
    input  logic [Y_POS_W-1:0] r_paddle_y_i,
    output logic [X_POS_W-1:0] ball_x_o,
    output logic [Y_POS_W-1:0] ball_y_o,
    output logic               score_l_o,
    output logic               score_r_o,
    output logic               in_play_o
);
    localparam int YW1   = Y_POS_W + 1;
    localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

    localparam logic [X_POS_W-1:0] X_CENTRE = X_POS_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [Y_POS_W-1:0] Y_CENTRE = Y_POS_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [X_POS_W-1:0] X_MAX    = X_POS_W'(SCREEN_W - BALL_SIZE);
    localparam logic [Y_POS_W-1:0] Y_MAX    = Y_POS_W'(SCREEN_H - BALL_SIZE);
    localparam logic [X_POS_W-1:0] L_FACE   = X_POS_W'(L_PADDLE_X + PADDLE_W);
    localparam logic [X_POS_W-1:0] R_FACE   = X_POS_W'(R_PADDLE_X - BALL_SIZE);
    localparam logic [X_POS_W-1:0] X_SPEED  = X_POS_W'(BALL_SPEED);
    localparam logic [Y_POS_W-1:0] Y_SPEED  = Y_POS_W'(BALL_SPEED);
    localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);

    ball_state_t        state;
    dir_t               dx;
    dir_t               dy;
    logic [CNT_W-1:0]   cnt;
    logic [X_POS_W-1:0] x_next;
    logic [Y_POS_W-1:0] y_next;
    dir_t               x_next_dir;
    dir_t               y_next_dir;
    logic               x_miss;
    logic               y_wall;
    logic               vov_l;
    logic               vov_r;
    logic               bounce_l;
    logic               bounce_r;

    function automatic logic overlaps(input logic [Y_POS_W-1:0] y, input logic [Y_POS_W-1:0] p);
        logic [YW1-1:0] y_bot;
        logic [YW1-1:0] p_bot;
        y_bot = {1'b0, y} + YW1'(BALL_SIZE);
        p_bot = {1'b0, p} + YW1'(PADDLE_H);
        return (y_bot > {1'b0, p}) && ({1'b0, y} < p_bot);
    endfunction

    // x limits are the miss lines, so the x hit flag means the ball left the court.
    ball_axis_step #(.W(X_POS_W)) u_x_step (
        .pos(ball_x_o), .dir(dx), .speed(X_SPEED), .lo('0), .hi(X_MAX),
        .next_pos(x_next), .next_dir(x_next_dir), .hit(x_miss)
    );

    ball_axis_step #(.W(Y_POS_W)) u_y_step (
        .pos(ball_y_o), .dir(dy), .speed(Y_SPEED), .lo('0), .hi(Y_MAX),
        .next_pos(y_next), .next_dir(y_next_dir), .hit(y_wall)
    );

    assign vov_l    = overlaps(ball_y_o, l_paddle_y_i);
    assign vov_r    = overlaps(ball_y_o, r_paddle_y_i);
    // A ball already behind a face (x past it) cannot bounce; it runs on to the miss line.
    assign bounce_l = (dx == NEG) && !x_miss && (x_next <= L_FACE) && (ball_x_o >= L_FACE) && vov_l;
    assign bounce_r = (dx == POS) && !x_miss && (x_next >= R_FACE) && (ball_x_o <= R_FACE) && vov_r;

    always_ff @(posedge clk_i) begin
        score_l_o <= 1'b0;
        score_r_o <= 1'b0;
        if (rst_i) begin
            state     <= IDLE;
            ball_x_o  <= X_CENTRE;
            ball_y_o  <= Y_CENTRE;
            dx        <= POS;
            dy        <= POS;
            cnt       <= '0;
            in_play_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state <= SERVE;
                        cnt   <= '0;
                    end
                end
                SERVE: begin
                    if (frame_tick_i) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == SERVE_LAST) begin
                            state     <= PLAY;
                            in_play_o <= 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (frame_tick_i) begin
                        ball_y_o <= y_next;
                        if (y_wall) begin
                            dy <= y_next_dir;
                        end
                        if (bounce_l) begin
                            ball_x_o <= L_FACE;
                            dx       <= POS;
                        end else if (bounce_r) begin
                            ball_x_o <= R_FACE;
                            dx       <= NEG;
                        end else if (x_miss) begin
                            score_r_o <= (dx == NEG);
                            score_l_o <= (dx == POS);
                            state     <= SCORED;
                            in_play_o <= 1'b0;
                        end else begin
                            ball_x_o <= x_next;
                            dx       <= x_next_dir;
                        end
                    end
                end
                SCORED: begin
                    // dx still points at the side that conceded, so the re-serve goes toward them.
                    ball_x_o <= X_CENTRE;
                    ball_y_o <= Y_CENTRE;
                    cnt      <= '0;
                    state    <= SERVE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ball_controller.sv
// tb/tb_ball_controller.sv - directed bench for ball_controller with hand-derived trajectories
module tb_ball_controller;
    import pong_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               frame_tick;
    logic               start;
    logic [Y_POS_W-1:0] l_paddle_y;
    logic [Y_POS_W-1:0] r_paddle_y;
    logic [X_POS_W-1:0] ball_x;
    logic [Y_POS_W-1:0] ball_y;
    logic               score_l;
    logic               score_r;
    logic               in_play;

    int   checks = 0;
    int   errors = 0;
    int   t = 0;
    logic track_l;
    logic track_r;

    ball_controller dut (
        .clk_i(clk), .rst_i(rst), .frame_tick_i(frame_tick), .start_i(start),
        .l_paddle_y_i(l_paddle_y), .r_paddle_y_i(r_paddle_y),
        .ball_x_o(ball_x), .ball_y_o(ball_y),
        .score_l_o(score_l), .score_r_o(score_r), .in_play_o(in_play)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag, input int x, input int y);
        check({tag, ".x"}, 32'(ball_x), x);
        check({tag, ".y"}, 32'(ball_y), y);
    endtask

    // Tracking paddle sits 20 px above the ball, which always overlaps it.
    function automatic logic [Y_POS_W-1:0] trk(input logic [Y_POS_W-1:0] y);
        return (y < Y_POS_W'(20)) ? '0 : y - Y_POS_W'(20);
    endfunction

    task automatic tick();
        @(negedge clk);
        if (track_l) l_paddle_y = trk(ball_y);
        if (track_r) r_paddle_y = trk(ball_y);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic adv(input int upto);
        while (t < upto) begin
            tick();
            t++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic serve(input string tag);
        for (int i = 0; i < 59; i++) tick();
        check({tag, ".s59.in_play"}, 32'(in_play), 0);
        check_pos({tag, ".s59"}, 315, 235);
        tick();
        check({tag, ".s60.in_play"}, 32'(in_play), 1);
        check_pos({tag, ".s60"}, 315, 235);
        t = 0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; start = 1'b0;
        l_paddle_y = '0; r_paddle_y = '0;
        track_l = 1'b1; track_r = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_pos("rst", 315, 235);
        check("rst.in_play", 32'(in_play), 0);
        check("rst.score_l", 32'(score_l), 0);
        check("rst.score_r", 32'(score_r), 0);

        tick(); tick();
        check("idle.in_play", 32'(in_play), 0);
        check_pos("idle", 315, 235);

        pulse_start();
        serve("a");
        adv(1);    check_pos("t1", 317, 237);
        adv(117);  check_pos("t117", 549, 469);
        adv(118);  check_pos("t118.bottom", 551, 470);
        adv(119);  check_pos("t119", 553, 468);
        adv(142);  check_pos("t142", 599, 422);
        adv(143);  check_pos("t143.rpad", 600, 420);
        adv(144);  check_pos("t144", 598, 418);
        adv(352);  check_pos("t352", 182, 2);
        adv(353);  check_pos("t353.top", 180, 0);
        adv(354);  check_pos("t354", 178, 2);
        adv(427);  check_pos("t427", 32, 148);
        adv(428);  check_pos("t428.lpad", 30, 150);
        check("t428.score_l", 32'(score_l), 0);
        check("t428.score_r", 32'(score_r), 0);
        adv(429);  check_pos("t429", 32, 152);
        adv(6697); check_pos("t6697", 32, 468);
        adv(6698); check_pos("t6698.corner", 30, 470);
        adv(6699); check_pos("t6699", 32, 468);

        pulse_start();
        check_pos("play.start", 32, 468);
        check("play.start.in_play", 32'(in_play), 1);
        adv(6700); check_pos("t6700", 34, 466);

        @(negedge clk);
        rst = 1'b1; frame_tick = 1'b1;
        @(negedge clk);
        rst = 1'b0; frame_tick = 1'b0;
        check_pos("rst_tick", 315, 235);
        check("rst_tick.in_play", 32'(in_play), 0);
        check("rst_tick.score_l", 32'(score_l), 0);
        check("rst_tick.score_r", 32'(score_r), 0);
        tick();
        check_pos("rst_idle", 315, 235);

        pulse_start();
        serve("b");
        adv(427);  check_pos("b427", 32, 148);
        track_l = 1'b0;
        l_paddle_y = Y_POS_W'(158);
        adv(428);  check_pos("b428.touch", 30, 150);
        l_paddle_y = Y_POS_W'(400);
        adv(429);  check_pos("b429.nobounce", 28, 152);
        l_paddle_y = Y_POS_W'(140);
        adv(430);  check_pos("b430.pastface", 26, 154);
        adv(442);  check_pos("b442", 2, 178);
        adv(443);
        check("miss.score_r", 32'(score_r), 1);
        check("miss.score_l", 32'(score_l), 0);
        check("miss.in_play", 32'(in_play), 0);
        check("miss.y", 32'(ball_y), 180);
        @(negedge clk);
        check("miss+1.score_r", 32'(score_r), 0);
        check_pos("miss+1", 315, 235);
        serve("c");
        adv(1);    check_pos("c1", 313, 237);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
